// File: rtl/ov7670_capture.sv
// ov7670_capture
// Camera-side capture stage for an OV7670 running RGB565. Pairs the two bytes
// of each pixel, expands the pixel to 8-bit R/G/B and produces linear
// frame-buffer write addresses with a one-cycle write strobe. Also handles
// frame sync, start-up frame skipping, optional 2:1 decimation in both axes,
// and sticky line-length error detection.
//
// Ports
//   cam_pclk        camera pixel clock, all logic on its rising edge
//   rst_n           asynchronous active-low reset
//   capture_en      level, request continuous capture
//   cam_vsync       high = vertical blanking
//   cam_href        high = active line bytes
//   cam_data_wires  camera data d7..d0
//   wr_en           one-cycle frame-buffer write strobe
//   wr_addr         linear write address (y*H_OUT + x) of the pixel on wr_en
//   pixel_data_R/G/B expanded 8-bit colour of the pixel on wr_en
//   frame_done      one-cycle pulse at the end of every captured frame
//   frame_count     captured-frame counter, wraps 255 -> 0
//   line_err        sticky: a captured line had the wrong length / odd bytes
module ov7670_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 2,
    parameter int DECIMATE    = 0,
    parameter int ADDR_W      = 19
) (
    input  logic              cam_pclk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data_wires,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        pixel_data_R,
    output logic [7:0]        pixel_data_G,
    output logic [7:0]        pixel_data_B,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              line_err
);

    // Counters get one spare value above the active size so an over-long
    // line is still distinguishable from a correct one.
    localparam int CX_W = $clog2(H_ACTIVE + 2);
    localparam int CY_W = $clog2(V_ACTIVE + 2);
    localparam int SK_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [CX_W-1:0] H_LIM = CX_W'(H_ACTIVE);
    localparam logic [CY_W-1:0] V_LIM = CY_W'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        WAIT_FRAME,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    state_t            state, state_nxt;
    logic [SK_W-1:0]   skip_cnt;
    logic              vsync_d, href_d;
    logic              phase;
    logic [7:0]        hi_byte;
    logic [CX_W-1:0]   cx;
    logic [CY_W-1:0]   cy;
    logic [ADDR_W-1:0] addr_cnt;

    logic    vsync_fall, vsync_rise, href_fall;
    logic    skip_load, skip_dec, frame_start, frame_end;
    logic    in_line, pix_done, qual;
    rgb565_t pix;

    assign vsync_fall = vsync_d & ~cam_vsync;
    assign vsync_rise = ~vsync_d & cam_vsync;
    assign href_fall  = href_d & ~cam_href;

    // A vsync rise ends the frame even with href still high; the byte on that
    // cycle is not taken, so any half-assembled pixel is dropped.
    assign in_line  = (state == ACTIVE) && cam_href && !vsync_rise;
    assign pix_done = in_line && phase;
    assign qual     = (cx < H_LIM) && (cy < V_LIM) &&
                      ((DECIMATE == 0) || (!cx[0] && !cy[0]));
    assign pix      = {hi_byte, cam_data_wires};

    always_comb begin
        state_nxt   = state;
        skip_load   = 1'b0;
        skip_dec    = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (capture_en) begin
                    skip_load = 1'b1;
                    state_nxt = (SKIP_FRAMES == 0) ? WAIT_FRAME : SKIP;
                end
            end
            SKIP: begin
                if (!capture_en) begin
                    state_nxt = IDLE;
                end else if (vsync_fall) begin
                    skip_dec = 1'b1;
                    // counter reaches zero on this decrement
                    if (skip_cnt <= SK_W'(1)) state_nxt = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!capture_en) begin
                    state_nxt = IDLE;
                end else if (vsync_fall) begin
                    frame_start = 1'b1;
                    state_nxt   = ACTIVE;
                end
            end
            ACTIVE: begin
                // capture_en is only looked at here, so a frame in progress
                // always runs to completion
                if (vsync_rise) begin
                    frame_end = 1'b1;
                    state_nxt = capture_en ? WAIT_FRAME : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            skip_cnt     <= '0;
            vsync_d      <= 1'b0;
            href_d       <= 1'b0;
            phase        <= 1'b0;
            hi_byte      <= '0;
            cx           <= '0;
            cy           <= '0;
            addr_cnt     <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            pixel_data_R <= '0;
            pixel_data_G <= '0;
            pixel_data_B <= '0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            line_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (skip_load)     skip_cnt <= SK_W'(SKIP_FRAMES);
            else if (skip_dec) skip_cnt <= skip_cnt - SK_W'(1);

            phase <= in_line ? ~phase : 1'b0;
            if (in_line && !phase) hi_byte <= cam_data_wires;

            if (frame_start) begin
                cx       <= '0;
                cy       <= '0;
                addr_cnt <= '0;
                wr_addr  <= '0;
            end else if (state == ACTIVE) begin
                if (href_fall) begin
                    // phase still holds the value left by the last byte,
                    // so phase=1 here means an odd byte count
                    if (cx != H_LIM || phase) line_err <= 1'b1;
                    cx <= '0;
                    if (cy != {CY_W{1'b1}}) cy <= cy + CY_W'(1);
                end else if (pix_done) begin
                    if (cx != {CX_W{1'b1}}) cx <= cx + CX_W'(1);
                    if (qual) begin
                        wr_en        <= 1'b1;
                        wr_addr      <= addr_cnt;
                        addr_cnt     <= addr_cnt + ADDR_W'(1);
                        pixel_data_R <= {pix.r, pix.r[4:2]};
                        pixel_data_G <= {pix.g, pix.g[5:4]};
                        pixel_data_B <= {pix.b, pix.b[4:2]};
                    end
                end
            end

            if (frame_end) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
`timescale 1ns/1ps
module tb_ov7670_capture;
    localparam int AW = 19;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs = 1'b1, hr = 1'b0;
    logic [7:0] d = 8'h00;
    logic       en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

    logic          we0, we1, we2, fd0, fd1, fd2, le0, le1, le2;
    logic [AW-1:0] wa0, wa1, wa2;
    logic [7:0]    r0, g0, b0, r1, g1, b1, r2, g2, b2, fc0, fc1, fc2;

    always #5 clk = ~clk;

    // u0: plain 4x2, u1: two skipped frames, u2: 2:1 decimation
    ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(0), .DECIMATE(0), .ADDR_W(AW)) u0 (
        .cam_pclk(clk), .rst_n(rst_n), .capture_en(en0), .cam_vsync(vs), .cam_href(hr),
        .cam_data_wires(d), .wr_en(we0), .wr_addr(wa0), .pixel_data_R(r0), .pixel_data_G(g0),
        .pixel_data_B(b0), .frame_done(fd0), .frame_count(fc0), .line_err(le0));
    ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(2), .DECIMATE(0), .ADDR_W(AW)) u1 (
        .cam_pclk(clk), .rst_n(rst_n), .capture_en(en1), .cam_vsync(vs), .cam_href(hr),
        .cam_data_wires(d), .wr_en(we1), .wr_addr(wa1), .pixel_data_R(r1), .pixel_data_G(g1),
        .pixel_data_B(b1), .frame_done(fd1), .frame_count(fc1), .line_err(le1));
    ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(0), .DECIMATE(1), .ADDR_W(AW)) u2 (
        .cam_pclk(clk), .rst_n(rst_n), .capture_en(en2), .cam_vsync(vs), .cam_href(hr),
        .cam_data_wires(d), .wr_en(we2), .wr_addr(wa2), .pixel_data_R(r2), .pixel_data_G(g2),
        .pixel_data_B(b2), .frame_done(fd2), .frame_count(fc2), .line_err(le2));

    typedef struct {
        logic [AW-1:0] a;
        logic [23:0]   rgb;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int nvec = 0, nerr = 0;
    int fdc0 = 0, fdc1 = 0, fdc2 = 0;
    logic [15:0] fpix [16];

    function automatic logic [23:0] expand(input logic [15:0] p);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = p[15:11];
        g = p[10:5];
        b = p[4:0];
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
    endfunction

    // scoreboard monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (fd0) fdc0++;
        if (we0) begin
            nvec++;
            if (q0.size() == 0) begin
                nerr++;
                $display("FAIL u0_write addr=%0d rgb=%06h required no write", wa0, {r0, g0, b0});
            end else begin
                e0 = q0.pop_front();
                if ({wa0, r0, g0, b0} !== {e0.a, e0.rgb}) begin
                    nerr++;
                    $display("FAIL u0_write addr=%0d rgb=%06h required addr=%0d rgb=%06h",
                             wa0, {r0, g0, b0}, e0.a, e0.rgb);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fd1) fdc1++;
        if (we1) begin
            nvec++;
            if (q1.size() == 0) begin
                nerr++;
                $display("FAIL u1_write addr=%0d rgb=%06h required no write", wa1, {r1, g1, b1});
            end else begin
                e1 = q1.pop_front();
                if ({wa1, r1, g1, b1} !== {e1.a, e1.rgb}) begin
                    nerr++;
                    $display("FAIL u1_write addr=%0d rgb=%06h required addr=%0d rgb=%06h",
                             wa1, {r1, g1, b1}, e1.a, e1.rgb);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fd2) fdc2++;
        if (we2) begin
            nvec++;
            if (q2.size() == 0) begin
                nerr++;
                $display("FAIL u2_write addr=%0d rgb=%06h required no write", wa2, {r2, g2, b2});
            end else begin
                e2 = q2.pop_front();
                if ({wa2, r2, g2, b2} !== {e2.a, e2.rgb}) begin
                    nerr++;
                    $display("FAIL u2_write addr=%0d rgb=%06h required addr=%0d rgb=%06h",
                             wa2, {r2, g2, b2}, e2.a, e2.rgb);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int id, input int a, input logic [23:0] rgb);
        exp_t e;
        e.a   = AW'(a);
        e.rgb = rgb;
        if (id == 0) q0.push_back(e);
        else if (id == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic push_frame(input int id);
        for (int i = 0; i < 8; i++) push_exp(id, i, expand(fpix[i]));
    endtask

    task automatic rand_pix();
        for (int i = 0; i < 16; i++) fpix[i] = 16'($urandom);
    endtask

    task automatic send_line(input int y, input int nbytes);
        logic [15:0] p;
        for (int b = 0; b < nbytes; b++) begin
            p  = fpix[(y * 4 + b / 2) % 16];
            hr = 1'b1;
            d  = b[0] ? p[7:0] : p[15:8];
            tick();
        end
        hr = 1'b0;
        d  = 8'h00;
        tick(3);
    endtask

    // drop_line >= 0 clears en0 right after that line
    task automatic send_frame(input int nlines, input int len0, input int lenr, input int drop_line);
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        tick(2);
        for (int y = 0; y < nlines; y++) begin
            send_line(y, (y == 0) ? len0 : lenr);
            if (y == drop_line) en0 = 1'b0;
        end
        vs = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        nvec++;
        if ({we0, wa0, r0, g0, b0, fd0, fc0, le0} !== '0) begin
            nerr++;
            $display("FAIL reset_u0 got=%h required 0", {we0, wa0, r0, g0, b0, fd0, fc0, le0});
        end
        nvec++;
        if ({we1, wa1, r1, g1, b1, fd1, fc1, le1} !== '0) begin
            nerr++;
            $display("FAIL reset_u1 got=%h required 0", {we1, wa1, r1, g1, b1, fd1, fc1, le1});
        end
        nvec++;
        if ({we2, wa2, r2, g2, b2, fd2, fc2, le2} !== '0) begin
            nerr++;
            $display("FAIL reset_u2 got=%h required 0", {we2, wa2, r2, g2, b2, fd2, fc2, le2});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        fpix[0] = 16'hF800; fpix[1] = 16'h07E0; fpix[2] = 16'h001F; fpix[3] = 16'h8410;
        fpix[4] = 16'h1234; fpix[5] = 16'hABCD; fpix[6] = 16'h5A5A; fpix[7] = 16'hFFFF;
        push_exp(0, 0, 24'hFF0000);
        push_exp(0, 1, 24'h00FF00);
        push_exp(0, 2, 24'h0000FF);
        push_exp(0, 3, 24'h848284);
        for (int i = 4; i < 8; i++) push_exp(0, i, expand(fpix[i]));
        en0 = 1'b1;
        tick();
        send_frame(2, 8, 8, -1);
        nvec++;
        if (q0.size() != 0) begin nerr++; $display("FAIL basic_writes missing=%0d required 0", q0.size()); end
        nvec++;
        if (fdc0 != 1) begin nerr++; $display("FAIL basic_frame_done pulses=%0d required 1", fdc0); end
        nvec++;
        if (fc0 !== 8'd1) begin nerr++; $display("FAIL basic_frame_count got=%0d required 1", fc0); end
        nvec++;
        if (le0 !== 1'b0) begin nerr++; $display("FAIL basic_line_err got=%b required 0", le0); end
    endtask

    task automatic test_colors();
        rand_pix();
        push_frame(0);
        send_frame(2, 8, 8, -1);
        nvec++;
        if (q0.size() != 0) begin nerr++; $display("FAIL colors_writes missing=%0d required 0", q0.size()); end
        nvec++;
        if (fc0 !== 8'd2) begin nerr++; $display("FAIL colors_frame_count got=%0d required 2", fc0); end
        en0 = 1'b0;
        tick(2);
    endtask

    task automatic test_skip();
        rand_pix();
        en1 = 1'b1;
        tick();
        for (int f = 1; f <= 4; f++) begin
            if (f >= 3) push_frame(1);
            send_frame(2, 8, 8, -1);
            if (f == 2) begin
                nvec++;
                if (fc1 !== 8'd0) begin nerr++; $display("FAIL skip_count_f2 got=%0d required 0", fc1); end
            end
        end
        nvec++;
        if (q1.size() != 0) begin nerr++; $display("FAIL skip_writes missing=%0d required 0", q1.size()); end
        nvec++;
        if (fc1 !== 8'd2) begin nerr++; $display("FAIL skip_frame_count got=%0d required 2", fc1); end
        nvec++;
        if (fdc1 != 2) begin nerr++; $display("FAIL skip_frame_done pulses=%0d required 2", fdc1); end
        en1 = 1'b0;
        tick(2);
    endtask

    task automatic test_decimate();
        rand_pix();
        en2 = 1'b1;
        tick();
        push_exp(2, 0, expand(fpix[0]));
        push_exp(2, 1, expand(fpix[2]));
        send_frame(2, 8, 8, -1);
        nvec++;
        if (q2.size() != 0) begin nerr++; $display("FAIL dec_writes missing=%0d required 0", q2.size()); end
        nvec++;
        if (le2 !== 1'b0) begin nerr++; $display("FAIL dec_line_err got=%b required 0", le2); end
        // three-pixel first line: still writes x=0,2, but flags the length
        push_exp(2, 0, expand(fpix[0]));
        push_exp(2, 1, expand(fpix[2]));
        send_frame(2, 6, 8, -1);
        nvec++;
        if (q2.size() != 0) begin nerr++; $display("FAIL dec_short_writes missing=%0d required 0", q2.size()); end
        nvec++;
        if (le2 !== 1'b1) begin nerr++; $display("FAIL short_line_err got=%b required 1", le2); end
        nvec++;
        if (fc2 !== 8'd2) begin nerr++; $display("FAIL dec_frame_count got=%0d required 2", fc2); end
        en2 = 1'b0;
        tick(2);
    endtask

    task automatic test_line_err();
        rand_pix();
        en0 = 1'b1;
        tick();
        for (int x = 0; x < 3; x++) push_exp(0, x, expand(fpix[x]));
        for (int x = 0; x < 4; x++) push_exp(0, 3 + x, expand(fpix[4 + x]));
        send_frame(2, 7, 8, -1);
        nvec++;
        if (le0 !== 1'b1) begin nerr++; $display("FAIL odd_line_err got=%b required 1", le0); end
        push_frame(0);
        send_frame(2, 8, 8, -1);
        nvec++;
        if (le0 !== 1'b1) begin nerr++; $display("FAIL sticky_line_err got=%b required 1", le0); end
        nvec++;
        if (q0.size() != 0) begin nerr++; $display("FAIL lerr_writes missing=%0d required 0", q0.size()); end
        nvec++;
        if (fc0 !== 8'd4) begin nerr++; $display("FAIL lerr_frame_count got=%0d required 4", fc0); end
        nvec++;
        if (le1 !== 1'b0) begin nerr++; $display("FAIL idle_line_err got=%b required 0", le1); end
    endtask

    task automatic test_drop_en();
        rand_pix();
        push_frame(0);
        send_frame(2, 8, 8, 0);
        nvec++;
        if (q0.size() != 0) begin nerr++; $display("FAIL drop_writes missing=%0d required 0", q0.size()); end
        nvec++;
        if (fdc0 != 5) begin nerr++; $display("FAIL drop_frame_done pulses=%0d required 5", fdc0); end
        nvec++;
        if (fc0 !== 8'd5) begin nerr++; $display("FAIL drop_frame_count got=%0d required 5", fc0); end
        send_frame(2, 8, 8, -1);
        nvec++;
        if (fc0 !== 8'd5) begin nerr++; $display("FAIL idle_frame_count got=%0d required 5", fc0); end
        nvec++;
        if (fdc0 != 5) begin nerr++; $display("FAIL idle_frame_done pulses=%0d required 5", fdc0); end
    endtask

    task automatic test_reset_midline();
        logic [15:0] p;
        rand_pix();
        en0 = 1'b1;
        tick();
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        tick(2);
        push_exp(0, 0, expand(fpix[0]));
        for (int b = 0; b < 4; b++) begin
            p  = fpix[b / 2];
            hr = 1'b1;
            d  = b[0] ? p[7:0] : p[15:8];
            tick();
        end
        // second pixel's strobe is high right now
        nvec++;
        if ({we0, wa0} !== {1'b1, AW'(1)}) begin
            nerr++;
            $display("FAIL pre_reset_write we=%b addr=%0d required we=1 addr=1", we0, wa0);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({we0, wa0, r0, g0, b0, fd0, fc0, le0} !== '0) begin
            nerr++;
            $display("FAIL midline_reset got=%h required 0", {we0, wa0, r0, g0, b0, fd0, fc0, le0});
        end
        nvec++;
        if (q0.size() != 0) begin nerr++; $display("FAIL midline_writes missing=%0d required 0", q0.size()); end
        hr  = 1'b0;
        vs  = 1'b1;
        en0 = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        nvec++;
        if ({we0, fc0, le0} !== '0) begin
            nerr++;
            $display("FAIL post_reset got=%h required 0", {we0, fc0, le0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_colors();
        test_skip();
        test_decimate();
        test_line_err();
        test_drop_en();
        test_reset_midline();
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
